// File: rtl/id_ex_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | id_ex_reg : ID/EX pipeline register with bubble insert, hold and        |
// |             late writeback capture. Optional PC save: PCSAVE_EN.        |
// | Revision  : 1.0                                                         |
// +------------------------------------------------------------------------+
module id_ex_reg #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          stallE,
  input  logic          flushE,
  input  logic          validD,
  input  logic [DW-1:0] rd1D,
  input  logic [DW-1:0] rd2D,
  input  logic [DW-1:0] signimmD,
  input  logic [5:0]    opD,
  input  logic [4:0]    rsD,
  input  logic [4:0]    rtD,
  input  logic [4:0]    rdD,
  input  logic [4:0]    saD,
  input  logic [AW-1:0] alucontrolD,
  input  logic          regwriteD,
  input  logic          memtoregD,
  input  logic          memwriteD,
  input  logic          alusrcD,
  input  logic          regdstD,
  input  logic          regwriteW,
  input  logic [4:0]    writeregW,
  input  logic [DW-1:0] resultW,
`ifdef PCSAVE_EN
  input  logic [31:0]   pcD,
  input  logic          is_dsD,
  output logic [31:0]   pcE,
  output logic          is_dsE,
`endif
  output logic [DW-1:0] rd1E,
  output logic [DW-1:0] rd2E,
  output logic [DW-1:0] signimmE,
  output logic [5:0]    opE,
  output logic [4:0]    rsE,
  output logic [4:0]    rtE,
  output logic [4:0]    rdE,
  output logic [4:0]    saE,
  output logic [AW-1:0] alucontrolE,
  output logic          regwriteE,
  output logic          memtoregE,
  output logic          memwriteE,
  output logic          alusrcE,
  output logic          regdstE,
  output logic          validE
);

  logic w_wb_live;
  logic w_late_rs;
  logic w_late_rt;

  // Writes to $0 are architecturally discarded, so they never refresh operands.
  assign w_wb_live = regwriteW && (writeregW != 5'd0);
  assign w_late_rs = w_wb_live && (writeregW == rsE);
  assign w_late_rt = w_wb_live && (writeregW == rtE);

  always_ff @(posedge clk) begin
    if (!rstn || flushE) begin
      rd1E        <= '0;
      rd2E        <= '0;
      signimmE    <= '0;
      opE         <= '0;
      rsE         <= '0;
      rtE         <= '0;
      rdE         <= '0;
      saE         <= '0;
      alucontrolE <= '0;
      regwriteE   <= 1'b0;
      memtoregE   <= 1'b0;
      memwriteE   <= 1'b0;
      alusrcE     <= 1'b0;
      regdstE     <= 1'b0;
      validE      <= 1'b0;
`ifdef PCSAVE_EN
      pcE         <= '0;
      is_dsE      <= 1'b0;
`endif
    end else if (stallE) begin
      // Held operands would otherwise miss a writeback that retires during the stall.
      if (w_late_rs) rd1E <= resultW;
      if (w_late_rt) rd2E <= resultW;
    end else begin
      rd1E        <= rd1D;
      rd2E        <= rd2D;
      signimmE    <= signimmD;
      opE         <= opD;
      rsE         <= rsD;
      rtE         <= rtD;
      rdE         <= rdD;
      saE         <= saD;
      alucontrolE <= alucontrolD;
      regwriteE   <= regwriteD & validD;
      memtoregE   <= memtoregD;
      memwriteE   <= memwriteD & validD;
      alusrcE     <= alusrcD;
      regdstE     <= regdstD;
      validE      <= validD;
`ifdef PCSAVE_EN
      pcE         <= pcD;
      is_dsE      <= is_dsD;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_id_ex_reg : directed + random self-checking bench for id_ex_reg.    |
// | Revision     : 1.0                                                     |
// +------------------------------------------------------------------------+
module tb_id_ex_reg;
  localparam int DW = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, stallE, flushE, validD;
  logic [DW-1:0] rd1D, rd2D, signimmD, resultW;
  logic [5:0] opD;
  logic [4:0] rsD, rtD, rdD, saD, writeregW;
  logic [AW-1:0] alucontrolD;
  logic regwriteD, memtoregD, memwriteD, alusrcD, regdstD, regwriteW;
  logic [DW-1:0] rd1E, rd2E, signimmE;
  logic [5:0] opE;
  logic [4:0] rsE, rtE, rdE, saE;
  logic [AW-1:0] alucontrolE;
  logic regwriteE, memtoregE, memwriteE, alusrcE, regdstE, validE;
`ifdef PCSAVE_EN
  logic [31:0] pcD, pcE;
  logic is_dsD, is_dsE;
`endif

  id_ex_reg #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .stallE(stallE), .flushE(flushE), .validD(validD),
    .rd1D(rd1D), .rd2D(rd2D), .signimmD(signimmD), .opD(opD),
    .rsD(rsD), .rtD(rtD), .rdD(rdD), .saD(saD), .alucontrolD(alucontrolD),
    .regwriteD(regwriteD), .memtoregD(memtoregD), .memwriteD(memwriteD),
    .alusrcD(alusrcD), .regdstD(regdstD),
    .regwriteW(regwriteW), .writeregW(writeregW), .resultW(resultW),
`ifdef PCSAVE_EN
    .pcD(pcD), .is_dsD(is_dsD), .pcE(pcE), .is_dsE(is_dsE),
`endif
    .rd1E(rd1E), .rd2E(rd2E), .signimmE(signimmE), .opE(opE),
    .rsE(rsE), .rtE(rtE), .rdE(rdE), .saE(saE), .alucontrolE(alucontrolE),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .memwriteE(memwriteE),
    .alusrcE(alusrcE), .regdstE(regdstE), .validE(validE)
  );

  // Expected E-stage contents.
  typedef struct packed {
    logic [DW-1:0] rd1, rd2, imm;
    logic [5:0]    op;
    logic [4:0]    rs, rt, rd, sa;
    logic [AW-1:0] alu;
    logic          rw, m2r, mw, asrc, rdst, v;
    logic [31:0]   pc;
    logic          ds;
  } st_t;

  st_t exp_s;
  int checks = 0;
  int errors = 0;

  // Next expected contents from the current inputs, by the stage's priority rules.
  function automatic st_t model_next(st_t cur);
    st_t n;
    n = cur;
    if (!rstn || flushE) begin
      n = '0;
    end else if (stallE) begin
      if (regwriteW && writeregW != 5'd0) begin
        if (writeregW == cur.rs) n.rd1 = resultW;
        if (writeregW == cur.rt) n.rd2 = resultW;
      end
    end else begin
      n.rd1 = rd1D; n.rd2 = rd2D; n.imm = signimmD; n.op = opD;
      n.rs = rsD; n.rt = rtD; n.rd = rdD; n.sa = saD; n.alu = alucontrolD;
      n.rw = regwriteD && validD; n.mw = memwriteD && validD;
      n.m2r = memtoregD; n.asrc = alusrcD; n.rdst = regdstD; n.v = validD;
`ifdef PCSAVE_EN
      n.pc = pcD; n.ds = is_dsD;
`endif
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd1E"}, 64'(rd1E), 64'(exp_s.rd1));
    chk({tag, ".rd2E"}, 64'(rd2E), 64'(exp_s.rd2));
    chk({tag, ".signimmE"}, 64'(signimmE), 64'(exp_s.imm));
    chk({tag, ".opE"}, 64'(opE), 64'(exp_s.op));
    chk({tag, ".rsE"}, 64'(rsE), 64'(exp_s.rs));
    chk({tag, ".rtE"}, 64'(rtE), 64'(exp_s.rt));
    chk({tag, ".rdE"}, 64'(rdE), 64'(exp_s.rd));
    chk({tag, ".saE"}, 64'(saE), 64'(exp_s.sa));
    chk({tag, ".alucontrolE"}, 64'(alucontrolE), 64'(exp_s.alu));
    chk({tag, ".ctrl"}, 64'({regwriteE, memtoregE, memwriteE, alusrcE, regdstE, validE}),
        64'({exp_s.rw, exp_s.m2r, exp_s.mw, exp_s.asrc, exp_s.rdst, exp_s.v}));
    chk({tag, ".bubble_no_write"}, 64'(!validE && (regwriteE || memwriteE)), 64'(0));
`ifdef PCSAVE_EN
    chk({tag, ".pcE"}, 64'(pcE), 64'(exp_s.pc));
    chk({tag, ".is_dsE"}, 64'(is_dsE), 64'(exp_s.ds));
`endif
  endtask

  // One clock: model follows the pre-edge inputs, outputs sampled 1 unit after the edge.
  task automatic step(input string tag);
    st_t nxt;
    nxt = model_next(exp_s);
    @(posedge clk);
    exp_s = nxt;
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    rstn = 1'b1; stallE = 1'b0; flushE = 1'b0; validD = 1'b0;
    rd1D = '0; rd2D = '0; signimmD = '0; opD = '0;
    rsD = '0; rtD = '0; rdD = '0; saD = '0; alucontrolD = '0;
    regwriteD = 1'b0; memtoregD = 1'b0; memwriteD = 1'b0; alusrcD = 1'b0; regdstD = 1'b0;
    regwriteW = 1'b0; writeregW = '0; resultW = '0;
`ifdef PCSAVE_EN
    pcD = '0; is_dsD = 1'b0;
`endif
  endtask

  task automatic random_inputs();
    rstn = ($urandom_range(0, 29) != 0);
    flushE = ($urandom_range(0, 7) == 0);
    stallE = ($urandom_range(0, 2) == 0);
    validD = ($urandom_range(0, 3) != 0);
    rd1D = $urandom; rd2D = $urandom; signimmD = $urandom; opD = 6'($urandom);
    rsD = 5'($urandom_range(0, 7)); rtD = 5'($urandom_range(0, 7));
    rdD = 5'($urandom); saD = 5'($urandom); alucontrolD = AW'($urandom);
    {regwriteD, memtoregD, memwriteD, alusrcD, regdstD} = 5'($urandom);
    regwriteW = ($urandom_range(0, 3) != 0);
    case ($urandom_range(0, 3))
      0: writeregW = exp_s.rs;
      1: writeregW = exp_s.rt;
      2: writeregW = 5'd0;
      default: writeregW = 5'($urandom);
    endcase
    resultW = $urandom;
`ifdef PCSAVE_EN
    pcD = $urandom; is_dsD = 1'($urandom);
`endif
  endtask

  initial begin
    exp_s = '0;
    idle_inputs();
    rstn = 1'b0;
    step("reset");

    // Load with zero-extended-looking immediate passed through untouched.
    rstn = 1'b1; validD = 1'b1; opD = 6'h0d; signimmD = 32'h0000_8001; rd1D = 32'h11;
    rsD = 5'd5; rtD = 5'd9; rd2D = 32'h22; regwriteD = 1'b1;
`ifdef PCSAVE_EN
    pcD = 32'hBFC0_0004; is_dsD = 1'b1;
`endif
    step("load");
    chk("load.signimm_direct", 64'(signimmE), 64'h0000_8001);
    chk("load.rd1_direct", 64'(rd1E), 64'h11);
`ifdef PCSAVE_EN
    chk("load.pc_direct", 64'(pcE), 64'hBFC0_0004);
`endif

    // Stall with a writeback to rsE.
    stallE = 1'b1; rd1D = 32'h99; regwriteW = 1'b1; writeregW = 5'd5; resultW = 32'hDEAD_BEEF;
    step("stall_late_rs");
    chk("stall_late_rs.direct", 64'(rd1E), 64'hDEAD_BEEF);

    // Stall with a writeback to $0 must not touch operands.
    writeregW = 5'd0; resultW = 32'hFFFF_FFFF;
    step("stall_wb_zero");

    // Writeback hitting rtE only.
    writeregW = 5'd9; resultW = 32'h1234_5678;
    step("stall_late_rt");

    // Same register on both sources updates both.
    stallE = 1'b0; rsD = 5'd3; rtD = 5'd3; regwriteW = 1'b0;
    step("load_same_src");
    stallE = 1'b1; regwriteW = 1'b1; writeregW = 5'd3; resultW = 32'hCAFE_F00D;
    step("stall_late_both");

    // Late capture does not apply on a load.
    stallE = 1'b0; rsD = 5'd4; rd1D = 32'h4444; writeregW = 5'd4; resultW = 32'h5555;
    step("load_no_capture");

    // Invalid decode slot must not leak a write.
    validD = 1'b0; regwriteD = 1'b1; memwriteD = 1'b1; regwriteW = 1'b0;
    step("load_invalid");

    // Flush and stall together: bubble wins.
    validD = 1'b1; flushE = 1'b1; stallE = 1'b1;
    step("flush_stall");
    chk("flush_stall.valid_direct", 64'(validE), 64'h0);
`ifdef PCSAVE_EN
    chk("flush_stall.pc_direct", 64'(pcE), 64'h0);
`endif

    // Reset in the middle of a stall.
    flushE = 1'b0; stallE = 1'b0; signimmD = 32'hFFFF_FFFE;
    step("pre_reset_load");
    stallE = 1'b1;
    for (int i = 0; i < 3; i++) step("held");
    rstn = 1'b0;
    step("reset_in_stall");
    rstn = 1'b1; stallE = 1'b0; validD = 1'b1; rd1D = 32'hA5A5_0001;
    step("post_reset_load");

    for (int i = 0; i < 400; i++) begin
      random_inputs();
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter: DW, 32, datapath width of register operands and extended immediate.
REQ-002 Parameter: AW, 8, width of ALU control field.
REQ-003 Ports: clk in 1 rising-edge clock; rstn in 1 reset, synchronous, active-low.
REQ-004 Ports: stallE in 1 hold stage; flushE in 1 insert bubble; validD in 1 decode slot holds a real instruction.
REQ-005 Ports: rd1D, rd2D in DW register-file reads; signimmD in DW immediate from the extender (zero- or sign-extended per opcode); opD in 6 opcode.
REQ-006 Ports: rsD, rtD, rdD, saD in 5 each; alucontrolD in AW; regwriteD, memtoregD, memwriteD, alusrcD, regdstD in 1 each.
REQ-007 Ports: regwriteW in 1, writeregW in 5, resultW in DW writeback bus.
REQ-008 Ports: every D-suffixed data/control input has an E-suffixed output of equal width; validE out 1.
REQ-009 Ports (PCSAVE_EN only): pcD in 32, is_dsD in 1 -> pcE out 32, is_dsE out 1.

Function
REQ-010 All outputs SHALL be registered; latency D->E one clock.
REQ-011 Priority per edge SHALL be: reset > flushE > stallE > load.
REQ-012 Load (no flush, no stall): every E output SHALL take its D input; validE <= validD.
REQ-013 Flush: validE <= 0; regwriteE, memwriteE, memtoregE <= 0; all data/field outputs <= 0 (bubble = sll $0,$0,0).
REQ-014 flushE and stallE both high SHALL flush (bubble wins).
REQ-015 Stall: all outputs SHALL hold, except late-write capture per REQ-016.
REQ-016 Late-write capture while stalled: if regwriteW=1, writeregW!=0, writeregW==rsE then rd1E <= resultW; same for rtE/rd2E; both may update in one cycle.
REQ-017 writeregW==0 SHALL never modify rd1E/rd2E.
REQ-018 Late-write capture SHALL NOT apply on load cycles; the register file supplies write-before-read.
REQ-019 When validE=0, regwriteE and memwriteE SHALL be 0 regardless of other state.
REQ-020 signimmE SHALL be passed unmodified; no re-extension in this stage.
REQ-021 No combinational path from any input to any output.

Reset
REQ-022 rstn=0 at a clock edge SHALL clear every output to 0, including validE and (PCSAVE_EN) pcE, is_dsE.
REQ-023 Reset mid-stall SHALL discard held state; first edge after rstn=1 behaves per REQ-011.

Configuration
REQ-024 Macro PCSAVE_EN: when defined, pcE/is_dsE exist, load/hold like data fields, flush to 0; stall leaves them unchanged.
REQ-025 Without PCSAVE_EN: pcD/is_dsD/pcE/is_dsE ports SHALL not exist; all other behaviour identical.

Verification
REQ-026 Load: validD=1, opD=6'h0d, signimmD=32'h0000_8001, rd1D=32'h11 -> next edge signimmE=32'h0000_8001, opE=6'h0d, rd1E=32'h11, validE=1.
REQ-027 Stall+late write: rsE=5, stallE=1, regwriteW=1, writeregW=5, resultW=32'hDEAD_BEEF -> rd1E=32'hDEAD_BEEF next edge, all other outputs unchanged.
REQ-028 Write to $0: rsE=0, rtE=0, stallE=1, regwriteW=1, writeregW=0, resultW=32'hFFFF_FFFF -> rd1E, rd2E unchanged.
REQ-029 Flush+stall: flushE=1, stallE=1, regwriteD=1, memwriteD=1 -> validE=0, regwriteE=0, memwriteE=0, all data outputs 0.
REQ-030 Reset during stall: load signimmD=32'hFFFF_FFFE, hold stallE=1 three cycles, rstn=0 one edge -> all outputs 0; rstn=1, load validD=1 -> normal capture next edge.
REQ-031 PCSAVE_EN: pcD=32'hBFC0_0004, is_dsD=1 load -> pcE=32'hBFC0_0004, is_dsE=1; then flushE=1 -> both 0.
